// File: rtl/ifu.sv
// ---------------------------------------------------------------------------
// ifu: instruction fetch unit.
//
// A two-state fetch sequencer. In REQ it requests the word at pc from
// instruction memory and waits, for any number of cycles, for imem_ack. The
// returned word is captured into instr and the unit moves to HOLD. In HOLD it
// presents instr/pc as valid until downstream asserts instr_ready. At that
// edge the unit samples npc_sel/zero, loads the next pc (sequential, beq
// target or j target) and returns to REQ.
//
// Ports
//   clk, rst_n           rising-edge clock, synchronous active-low reset
//   npc_sel, zero        branch/jump request and ALU equality flag (HOLD only)
//   imem_req, imem_addr  instruction memory request and word-aligned address
//   imem_ack, imem_rdata memory completion strobe and returned word
//   instr, instr_valid   held instruction and its valid flag
//   instr_ready          downstream has finished with instr
//   pc                   address of instr
//   opcode, funct        instr[31:26] and instr[5:0]
// ---------------------------------------------------------------------------
module ifu (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        npc_sel,
  input  logic        zero,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] pc,
  output logic [5:0]  opcode,
  output logic [5:0]  funct
);

  localparam logic [31:0] ResetPc = 32'h0000_3000;
  localparam logic [5:0]  OpJ     = 6'b000010;

  typedef enum logic [0:0] {StReq, StHold} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;

  logic [31:0] pc4;
  logic [31:0] br_offset;
  logic [31:0] br_target;
  logic [31:0] j_target;
  logic [31:0] npc;

  // Next-pc datapath. Every add wraps modulo 2^32 by construction.
  always_comb begin
    pc4       = pc_q + 32'd4;
    br_offset = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
    br_target = pc4 + br_offset;
    j_target  = {pc4[31:28], instr_q[25:0], 2'b00};
    npc       = pc4;
    if (npc_sel) begin
      if (instr_q[31:26] == OpJ) begin
        npc = j_target;
      end else if (zero) begin
        npc = br_target;
      end
    end
  end

  // Next-state logic. Only the input relevant to the current state acts:
  // ack in REQ, ready in HOLD; everything else is ignored.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    unique case (state_q)
      StReq: begin
        if (imem_ack) begin
          instr_d = imem_rdata;
          state_d = StHold;
        end
      end
      StHold: begin
        if (instr_ready) begin
          pc_d    = npc;
          state_d = StReq;
        end
      end
      default: state_d = StReq;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StReq;
      pc_q    <= ResetPc;
      instr_q <= 32'h0000_0000;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  // Outputs are decoded straight from the registers so nothing is X once a
  // reset edge has been seen.
  always_comb begin
    imem_req    = (state_q == StReq);
    instr_valid = (state_q == StHold);
    // pc is always word aligned; the low bits are tied off explicitly.
    imem_addr   = {pc_q[31:2], 2'b00};
    instr       = instr_q;
    pc          = pc_q;
    opcode      = instr_q[31:26];
    funct       = instr_q[5:0];
  end

endmodule

// File: tb/tb_ifu.sv
// ---------------------------------------------------------------------------
// tb_ifu: self-checking bench for ifu. A behavioural model tracks whether a
// fetch is outstanding plus the architectural pc/instr; a compare process
// checks every DUT output against it on each falling edge. Directed
// scenarios add literal checks that pin the model, followed by a randomized
// phase.
// ---------------------------------------------------------------------------
module tb_ifu;

  logic        clk;
  logic        rst_n;
  logic        npc_sel;
  logic        zero;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] pc;
  logic [5:0]  opcode;
  logic [5:0]  funct;

  int n_tests = 0;
  int n_fail  = 0;

  ifu dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .npc_sel     (npc_sel),
    .zero        (zero),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .pc          (pc),
    .opcode      (opcode),
    .funct       (funct)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic        m_known = 1'b0;  // set once a reset edge has been seen
  logic        m_fetching;      // 1: waiting for memory, 0: holding instr
  logic [31:0] m_pc;
  logic [31:0] m_instr;

  function automatic logic [31:0] ref_npc(input logic [31:0] p, input logic [31:0] i,
                                          input logic s, input logic z);
    logic [31:0] p4;
    logic [31:0] off;
    p4  = p + 32'd4;
    off = {{14{i[15]}}, i[15:0], 2'b00};
    if (!s) return p4;
    if (i[31:26] == 6'd2) return {p4[31:28], i[25:0], 2'b00};
    if (z) return p4 + off;
    return p4;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m_known    <= 1'b1;
      m_fetching <= 1'b1;
      m_pc       <= 32'h0000_3000;
      m_instr    <= 32'h0;
    end else if (m_known) begin
      if (m_fetching && imem_ack) begin
        m_instr    <= imem_rdata;
        m_fetching <= 1'b0;
      end else if (!m_fetching && instr_ready) begin
        m_pc       <= ref_npc(m_pc, m_instr, npc_sel, zero);
        m_fetching <= 1'b1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    if (m_known) begin
      chk("m_imem_req", {31'b0, imem_req}, {31'b0, m_fetching});
      chk("m_instr_valid", {31'b0, instr_valid}, {31'b0, !m_fetching});
      if (m_fetching) chk("m_imem_addr", imem_addr, m_pc);
      chk("m_pc", pc, m_pc);
      chk("m_instr", instr, m_instr);
      chk("m_opcode", {26'b0, opcode}, {26'b0, m_instr[31:26]});
      chk("m_funct", {26'b0, funct}, {26'b0, m_instr[5:0]});
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
  endtask

  // Ack in the first REQ cycle.
  task automatic fetch(input logic [31:0] word);
    imem_ack   = 1'b1;
    imem_rdata = word;
    cyc();
    imem_ack   = 1'b0;
    imem_rdata = $urandom;
  endtask

  task automatic retire(input logic s, input logic z);
    instr_ready = 1'b1;
    npc_sel     = s;
    zero        = z;
    cyc();
    instr_ready = 1'b0;
    npc_sel     = $urandom_range(0, 1);
    zero        = $urandom_range(0, 1);
  endtask

  initial begin
    rst_n = 1'b1; npc_sel = 1'b0; zero = 1'b0;
    imem_ack = 1'b0; imem_rdata = 32'h0; instr_ready = 1'b0;
    cyc();

    // Reset then sequential fetch.
    imem_ack = 1'b1;  // stray ack during reset must be discarded
    rst_n = 1'b0; cyc(); rst_n = 1'b1; imem_ack = 1'b0;
    chk("rst_req", {31'b0, imem_req}, 32'd1);
    chk("rst_addr", imem_addr, 32'h3000);
    chk("rst_valid", {31'b0, instr_valid}, 32'd0);
    chk("rst_instr", instr, 32'h0);
    fetch(32'h0000_0020);
    chk("seq_valid1", {31'b0, instr_valid}, 32'd1);
    retire(1'b0, 1'b1);
    chk("seq_addr1", imem_addr, 32'h3004);
    chk("seq_valid2", {31'b0, instr_valid}, 32'd0);
    fetch(32'h0000_0021);
    chk("seq_valid3", {31'b0, instr_valid}, 32'd1);
    retire(1'b0, 1'b0);
    chk("seq_addr2", imem_addr, 32'h3008);

    // Memory stall at 0x3000.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      chk("stall_req", {31'b0, imem_req}, 32'd1);
      chk("stall_addr", imem_addr, 32'h3000);
      cyc();
    end
    chk("stall_req4", {31'b0, imem_req}, 32'd1);
    fetch(32'h1234_5678);
    chk("stall_valid", {31'b0, instr_valid}, 32'd1);
    chk("stall_instr", instr, 32'h1234_5678);
    retire(1'b0, 1'b0);

    // Walk to 0x3010, beq taken.
    for (int i = 0; i < 3; i++) begin fetch(32'h0); retire(1'b0, 1'b0); end
    chk("beq_pc", pc, 32'h3010);
    fetch(32'h1000_FFFE);
    retire(1'b1, 1'b1);
    chk("beq_taken", pc, 32'h300C);
    fetch(32'h0); retire(1'b0, 1'b0);
    fetch(32'h1000_FFFE);
    retire(1'b1, 1'b0);
    chk("beq_not_taken", pc, 32'h3014);

    // j at 0x3020 with zero=1, then return there and repeat with zero=0.
    for (int i = 0; i < 3; i++) begin fetch(32'h0); retire(1'b0, 1'b0); end
    chk("j_pc", pc, 32'h3020);
    fetch(32'h0800_0C40);
    retire(1'b1, 1'b1);
    chk("j_zero1", pc, 32'h3100);
    fetch(32'h1000_FFC7);  // beq back to 0x3020
    retire(1'b1, 1'b1);
    chk("beq_back", pc, 32'h3020);
    fetch(32'h0800_0C40);
    retire(1'b1, 1'b0);
    chk("j_zero0", pc, 32'h3100);

    // Downstream stall with stray acks.
    fetch(32'hCAFE_0001);
    for (int i = 0; i < 5; i++) begin
      imem_ack = i[0]; imem_rdata = 32'hBAD0_0000 | i;
      cyc();
      chk("hold_instr", instr, 32'hCAFE_0001);
      chk("hold_pc", pc, 32'h3100);
      chk("hold_req", {31'b0, imem_req}, 32'd0);
    end
    imem_ack = 1'b0;
    retire(1'b0, 1'b0);

    // Reset mid-fetch with ack asserted.
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF; rst_n = 1'b0;
    cyc();
    rst_n = 1'b1; imem_ack = 1'b0;
    chk("rstreq_pc", pc, 32'h3000);
    chk("rstreq_instr", instr, 32'h0);
    chk("rstreq_valid", {31'b0, instr_valid}, 32'd0);

    // Reach 0xFFFF_FFFC: beq far backwards wraps, then j in the top region.
    fetch(32'h1000_8000);
    retire(1'b1, 1'b1);
    chk("wrap_beq", pc, 32'hFFFE_3004);
    fetch(32'h0BFF_FFFF);
    retire(1'b1, 1'b0);
    chk("wrap_j", pc, 32'hFFFF_FFFC);
    fetch(32'h0);
    retire(1'b0, 1'b1);
    chk("wrap_seq", pc, 32'h0000_0000);
    chk("wrap_addr", imem_addr, 32'h0000_0000);

    // Randomized phase, checked by the per-cycle compare.
    for (int i = 0; i < 600; i++) begin
      rst_n       = ($urandom_range(0, 59) != 0);
      imem_ack    = $urandom_range(0, 2) != 0;
      instr_ready = $urandom_range(0, 2) != 0;
      npc_sel     = $urandom_range(0, 1);
      zero        = $urandom_range(0, 1);
      imem_rdata  = $urandom;
      if ($urandom_range(0, 3) == 0) imem_rdata[31:26] = 6'b000010;
      cyc();
    end
    rst_n = 1'b1; imem_ack = 1'b0; instr_ready = 1'b0;
    cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ifu.md
IFU -- requirements
Module: ifu

Interface
REQ-001 The block SHALL have exactly one clock, clk, and one reset, rst_n; reset is synchronous and active-low.
REQ-002 The ports SHALL be as listed below.

| Port | Direction | Width | Meaning |
|---|---|---|---|
| clk | in | 1 | rising-edge clock |
| rst_n | in | 1 | synchronous active-low reset |
| npc_sel | in | 1 | branch/jump request from controller, sampled in HOLD |
| zero | in | 1 | ALU equality flag, sampled in HOLD |
| imem_req | out | 1 | instruction memory read request |
| imem_addr | out | 32 | word-aligned fetch address |
| imem_ack | in | 1 | memory read complete; imem_rdata valid this cycle |
| imem_rdata | in | 32 | instruction word |
| instr | out | 32 | fetched instruction |
| instr_valid | out | 1 | instr/pc hold a valid instruction |
| instr_ready | in | 1 | downstream has finished executing instr |
| pc | out | 32 | address of instr |
| opcode | out | 6 | instr[31:26] |
| funct | out | 6 | instr[5:0] |

Function
REQ-003 The FSM SHALL have the states REQ and HOLD; reset enters REQ.
REQ-004 In REQ: imem_req=1, imem_addr=pc, instr_valid=0.
REQ-005 In REQ with imem_ack=1: instr<=imem_rdata at the edge, then go to HOLD. Ack may arrive in the first REQ cycle.
REQ-006 In REQ with imem_ack=0: stay in REQ, with imem_req and imem_addr held stable, for any number of cycles.
REQ-007 In HOLD: imem_req=0, instr_valid=1, and instr and pc are stable.
REQ-008 In HOLD with instr_ready=1: pc<=npc at the edge, then go to REQ. With instr_ready=0, stay in HOLD.
REQ-009 pc4 SHALL equal pc+4 modulo 2^32; 0xFFFF_FFFC wraps to 0x0000_0000.
REQ-010 npc SHALL be selected as follows.
- npc_sel=1 and opcode=6'b000010 (j): npc = {pc4[31:28], instr[25:0], 2'b00}.
- npc_sel=1, opcode≠j, zero=1 (beq taken): npc = pc4 + (sign_ext(instr[15:0])<<2), modulo 2^32.
- npc_sel=1, opcode≠j, zero=0: npc = pc4.
- npc_sel=0: npc = pc4, regardless of zero.
REQ-011 npc_sel and zero SHALL be sampled only in the HOLD cycle where instr_ready=1. They are ignored at all other times.
REQ-012 imem_ack outside REQ SHALL be ignored, with no state or data change.
REQ-013 opcode and funct SHALL be combinational slices of the registered instr.
REQ-014 imem_addr[1:0] SHALL always be 2'b00.
REQ-015 Minimum fetch latency: one cycle from entering REQ to instr_valid=1 (ack in the first REQ cycle).
REQ-016 Minimum instruction period: two cycles, one REQ plus one HOLD.
REQ-017 imem_ack and instr_ready in the same cycle: only the input relevant to the current state acts (ack in REQ, ready in HOLD).

Reset
REQ-018 When rst_n=0 at a rising edge, the next state SHALL be:
- pc=0x0000_3000
- instr=0x0000_0000
- state REQ, with imem_req=1, imem_addr=0x0000_3000 and instr_valid=0 from the following cycle
REQ-019 Reset SHALL override every state. A reset during REQ abandons the fetch, and any ack in the reset cycle is discarded.
REQ-020 Reset during HOLD SHALL discard the held instruction, with no pc update from npc.
REQ-021 All outputs SHALL have defined values in the cycle after a reset edge; no output is X.

Verification
REQ-022 The bench SHALL cover these directed scenarios.
- Reset then sequential fetch: ack every first REQ cycle, ready=1, npc_sel=0 -> imem_addr sequence 0x3000, 0x3004, 0x3008; instr_valid pattern 0,1,0,1.
- Memory stall: ack delayed 3 cycles at pc=0x3000 -> imem_req=1 and addr=0x3000 held 4 cycles; instr_valid rises the cycle after ack.
- beq: pc=0x3010, instr=0x1000_FFFE, npc_sel=1. zero=1 gives next pc=0x300C; zero=0 gives 0x3014.
- j: pc=0x3020, instr=0x0800_0C40, npc_sel=1 -> next pc=0x0000_3100, independent of zero.
- Downstream stall and stray ack: HOLD with ready=0 for 5 cycles, ack pulsed -> instr and pc unchanged, no request issued.
- Reset mid-fetch and wrap: rst_n=0 in REQ with ack=1 -> pc=0x3000, instr=0, valid=0. Forced pc=0xFFFF_FFFC, sequential -> next pc=0x0000_0000.
